// File: rtl/alu_issue_ctrl_if.sv
// Request/response bundle between decode and the ALU issue controller.
// Carries the instruction-field handshake in and the writeback/branch handshake out.
interface alu_issue_ctrl_if #(
   parameter int XLEN = 32
);
   logic            in_valid;
   logic            in_ready;
   logic [1:0]      in_class;
   logic [2:0]      in_funct3;
   logic            in_funct7_5;
   logic [XLEN-1:0] in_a;
   logic [XLEN-1:0] in_b;
   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] out_result;
   logic            out_taken;
   logic            out_illegal;

   modport master (
      output in_valid, in_class, in_funct3, in_funct7_5, in_a, in_b, out_ready,
      input  in_ready, out_valid, out_result, out_taken, out_illegal
   );

   modport slave (
      input  in_valid, in_class, in_funct3, in_funct7_5, in_a, in_b, out_ready,
      output in_ready, out_valid, out_result, out_taken, out_illegal
   );
endinterface

// File: rtl/alu_issue_ctrl.sv
// Issues decoded RISC-V ALU/branch ops to a combinational ALU and collects
// the result, SLT/SLTU value and branch decision one cycle later.
module alu_issue_ctrl #(
   parameter int XLEN = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   alu_issue_ctrl_if.slave       bus,
   output logic [2:0]            alu_ctrl,
   output logic [XLEN-1:0]       alu_a,
   output logic [XLEN-1:0]       alu_b,
   input  logic [XLEN-1:0]       alu_out,
   input  logic                  alu_zero,
   input  logic                  alu_slt,
   input  logic                  alu_sltu
);
   localparam logic [2:0] OP_ADD = 3'd0;
   localparam logic [2:0] OP_SUB = 3'd1;
   localparam logic [2:0] OP_AND = 3'd2;
   localparam logic [2:0] OP_OR  = 3'd3;
   localparam logic [2:0] OP_XOR = 3'd4;
   localparam logic [2:0] OP_SLL = 3'd5;
   localparam logic [2:0] OP_SRA = 3'd6;
   localparam logic [2:0] OP_SRL = 3'd7;

   typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
   typedef enum logic [1:0] {SEL_ALU, SEL_SLT, SEL_SLTU, SEL_ZERO} res_sel_t;

   state_t          state, next_state;
   logic            ready_c;
   logic            accept;

   logic [2:0]      d_ctrl;
   logic [XLEN-1:0] d_a, d_b;
   logic            d_illegal, d_branch;
   res_sel_t        d_sel;

   res_sel_t        sel_q;
   logic            branch_q, illegal_q;
   logic [2:0]      funct3_q;

   logic [XLEN-1:0] res_c;
   logic            taken_c;

   logic            out_valid_q, out_taken_q, out_illegal_q;
   logic [XLEN-1:0] out_result_q;

   assign bus.in_ready    = ready_c & ~reset;
   assign accept          = bus.in_valid & bus.in_ready;
   assign bus.out_valid   = out_valid_q;
   assign bus.out_result  = out_result_q;
   assign bus.out_taken   = out_taken_q;
   assign bus.out_illegal = out_illegal_q;

   // State register; reset drops any in-flight op.
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= next_state;
   end

   // Next state and ready: accept from IDLE, or from DONE when the result leaves this cycle.
   always_comb begin
      next_state = state;
      ready_c    = 1'b0;
      case (state)
         IDLE: begin
            ready_c = 1'b1;
            if (bus.in_valid) next_state = EXEC;
         end
         EXEC: next_state = DONE;
         DONE: begin
            if (bus.out_ready) begin
               ready_c    = 1'b1;
               next_state = bus.in_valid ? EXEC : IDLE;
            end
         end
         default: next_state = IDLE;
      endcase
   end

   // Decode instruction class/funct fields into ALU code, operands and result selection.
   always_comb begin
      d_ctrl    = OP_ADD;
      d_a       = bus.in_a;
      d_b       = bus.in_b;
      d_illegal = 1'b0;
      d_branch  = 1'b0;
      d_sel     = SEL_ALU;
      case (bus.in_class)
         2'b00, 2'b01: begin
            case (bus.in_funct3)
               3'b000: d_ctrl = (bus.in_class == 2'b00 && bus.in_funct7_5) ? OP_SUB : OP_ADD;
               3'b001: begin
                  d_ctrl = OP_SLL;
                  d_b    = {{(XLEN-5){1'b0}}, bus.in_b[4:0]};
               end
               3'b010: begin
                  d_ctrl = OP_SUB;
                  d_sel  = SEL_SLT;
               end
               3'b011: begin
                  d_ctrl = OP_SUB;
                  d_sel  = SEL_SLTU;
               end
               3'b100: d_ctrl = OP_XOR;
               3'b101: begin
                  d_ctrl = bus.in_funct7_5 ? OP_SRA : OP_SRL;
                  d_b    = {{(XLEN-5){1'b0}}, bus.in_b[4:0]};
               end
               3'b110: d_ctrl = OP_OR;
               default: d_ctrl = OP_AND;
            endcase
            // R-type reserves bit 30 except for SUB/SRA; I-type only reserves it on SLLI.
            if (bus.in_class == 2'b00 && bus.in_funct7_5 &&
                bus.in_funct3 != 3'b000 && bus.in_funct3 != 3'b101)
               d_illegal = 1'b1;
            if (bus.in_class == 2'b01 && bus.in_funct7_5 && bus.in_funct3 == 3'b001)
               d_illegal = 1'b1;
         end
         2'b10: begin
            d_ctrl   = OP_SUB;
            d_branch = 1'b1;
            d_sel    = SEL_ZERO;
            if (bus.in_funct3 == 3'b010 || bus.in_funct3 == 3'b011) d_illegal = 1'b1;
         end
         default: d_illegal = 1'b1;
      endcase
      if (d_illegal) begin
         d_ctrl   = OP_ADD;
         d_a      = '0;
         d_b      = '0;
         d_branch = 1'b0;
         d_sel    = SEL_ZERO;
      end
   end

   // Form writeback value and branch decision from the ALU result and flags.
   always_comb begin
      res_c   = alu_out;
      taken_c = 1'b0;
      case (sel_q)
         SEL_SLT:  res_c = {{(XLEN-1){1'b0}}, alu_slt};
         SEL_SLTU: res_c = {{(XLEN-1){1'b0}}, alu_sltu};
         SEL_ZERO: res_c = '0;
         default:  res_c = alu_out;
      endcase
      if (branch_q) begin
         case (funct3_q)
            3'b000:  taken_c = alu_zero;
            3'b001:  taken_c = ~alu_zero;
            3'b100:  taken_c = alu_slt;
            3'b101:  taken_c = ~alu_slt;
            3'b110:  taken_c = alu_sltu;
            3'b111:  taken_c = ~alu_sltu;
            default: taken_c = 1'b0;
         endcase
      end
   end

   // Register the issued op on accept and capture its result during EXEC.
   always_ff @(posedge clk) begin
      if (reset) begin
         alu_ctrl      <= OP_ADD;
         alu_a         <= '0;
         alu_b         <= '0;
         sel_q         <= SEL_ALU;
         branch_q      <= 1'b0;
         illegal_q     <= 1'b0;
         funct3_q      <= 3'b000;
         out_valid_q   <= 1'b0;
         out_result_q  <= '0;
         out_taken_q   <= 1'b0;
         out_illegal_q <= 1'b0;
      end else begin
         if (accept) begin
            alu_ctrl  <= d_ctrl;
            alu_a     <= d_a;
            alu_b     <= d_b;
            sel_q     <= d_sel;
            branch_q  <= d_branch;
            illegal_q <= d_illegal;
            funct3_q  <= bus.in_funct3;
         end
         if (state == EXEC) begin
            out_valid_q   <= 1'b1;
            out_result_q  <= res_c;
            out_taken_q   <= taken_c;
            out_illegal_q <= illegal_q;
         end else if (state == DONE && bus.out_ready) begin
            out_valid_q <= 1'b0;
         end
      end
   end
endmodule
